// File: rtl/core_bus_arbiter_pkg.sv
// Shared types and constants for the core ibus/dbus to memory-bus arbiter.
// The CORE_BUS_ARB_PERF_EN build option only affects the top module.
package core_bus_arbiter_pkg;

    // Bus widths used by the latched request record.
    // They must match the top-level ADDR_W / DATA_W parameters.
    localparam int unsigned ARB_ADDR_W = 64;
    localparam int unsigned ARB_DATA_W = 64;

    // Every instruction fetch is a 4-byte access.
    localparam logic [2:0] SIZE_WORD = 3'd2;

    // Which master owns the transaction currently in flight.
    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // Request as presented on the memory side.
    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [7:0]            strobe;
        logic [ARB_DATA_W-1:0] data;
    } creq_t;

    localparam creq_t CREQ_CLEAR = '{
        write:  1'b0,
        addr:   {ARB_ADDR_W{1'b0}},
        size:   3'd0,
        strobe: 8'h00,
        data:   {ARB_DATA_W{1'b0}}
    };

    // Pick the 32-bit instruction lane out of a 64-bit beat.
    // The selector is address bit 2 of the fetch.
    function automatic logic [31:0] pick_word(input logic [ARB_DATA_W-1:0] beat,
                                              input logic                  upper);
        logic [31:0] word;
        if (upper) begin
            word = beat[63:32];
        end else begin
            word = beat[31:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/core_bus_rr_pick.sv
// Combinational two-way round-robin picker for the ibus/dbus arbiter.
// When both masters request, the one that was not granted last time wins.
module core_bus_rr_pick
    import core_bus_arbiter_pkg::*;
(
    input  logic   ireq_valid,
    input  logic   dreq_valid,
    input  owner_t last_grant,
    output logic   grant,
    output owner_t owner
);

    // Decide whether anyone wins this cycle and who it is.
    always_comb begin
        grant = 1'b0;
        owner = OWN_IBUS;
        case ({ireq_valid, dreq_valid})
            2'b10: begin
                grant = 1'b1;
                owner = OWN_IBUS;
            end
            2'b01: begin
                grant = 1'b1;
                owner = OWN_DBUS;
            end
            2'b11: begin
                grant = 1'b1;
                if (last_grant == OWN_IBUS) begin
                    owner = OWN_DBUS;
                end else begin
                    owner = OWN_IBUS;
                end
            end
            default: begin
                grant = 1'b0;
                owner = OWN_IBUS;
            end
        endcase
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch bus (ibus) and data bus (dbus) onto one memory-side bus.
// Only one transaction is ever outstanding: IDLE (grant) -> ISSUE (handshake) -> WAIT (response).
// All master-facing pulses and response data are registered.
// Build option: define CORE_BUS_ARB_PERF_EN to add the grant/conflict performance counters.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,
    output logic              creq_valid,
    input  logic              creq_ready,
    output logic              creq_write,
    output logic [ADDR_W-1:0] creq_addr,
    output logic [2:0]        creq_size,
    output logic [7:0]        creq_strobe,
    output logic [DATA_W-1:0] creq_data,
    input  logic              cresp_valid,
    input  logic [DATA_W-1:0] cresp_data
`ifdef CORE_BUS_ARB_PERF_EN
    ,
    output logic [31:0]       perf_igrant,
    output logic [31:0]       perf_dgrant,
    output logic [31:0]       perf_conflict
`endif
);

    arb_state_t        state_q,       state_d;
    owner_t            last_grant_q,  last_grant_d;
    owner_t            owner_q,       owner_d;
    creq_t             req_q,         req_d;
    logic              creq_valid_q,  creq_valid_d;
    logic              iaddr_ok_q,    iaddr_ok_d;
    logic              daddr_ok_q,    daddr_ok_d;
    logic              idata_ok_q,    idata_ok_d;
    logic              ddata_ok_q,    ddata_ok_d;
    logic [31:0]       iresp_data_q,  iresp_data_d;
    logic [DATA_W-1:0] dresp_data_q,  dresp_data_d;

    logic              pick_grant_s;
    owner_t            pick_owner_s;

    core_bus_rr_pick u_rr_pick (
        .ireq_valid (ireq_valid),
        .dreq_valid (dreq_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant_s),
        .owner      (pick_owner_s)
    );

    // Next-state, request latch and response register logic of the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        req_d        = req_q;
        creq_valid_d = creq_valid_q;
        iaddr_ok_d   = 1'b0;
        daddr_ok_d   = 1'b0;
        idata_ok_d   = 1'b0;
        ddata_ok_d   = 1'b0;
        iresp_data_d = iresp_data_q;
        dresp_data_d = dresp_data_q;

        case (state_q)
            ARB_IDLE: begin
                // Responses arriving here are stale (e.g. from before a reset) and are dropped.
                if (pick_grant_s) begin
                    owner_d      = pick_owner_s;
                    last_grant_d = pick_owner_s;
                    creq_valid_d = 1'b1;
                    state_d      = ARB_ISSUE;
                    if (pick_owner_s == OWN_IBUS) begin
                        req_d = '{write:  1'b0,
                                  addr:   ireq_addr,
                                  size:   SIZE_WORD,
                                  strobe: 8'h00,
                                  data:   {ARB_DATA_W{1'b0}}};
                    end else begin
                        req_d = '{write:  |dreq_strobe,
                                  addr:   dreq_addr,
                                  size:   dreq_size,
                                  strobe: dreq_strobe,
                                  data:   dreq_data};
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                // Request held stable until memory takes it.
                if (creq_ready) begin
                    creq_valid_d = 1'b0;
                    state_d      = ARB_WAIT;
                    if (owner_q == OWN_IBUS) begin
                        iaddr_ok_d = 1'b1;
                    end else begin
                        daddr_ok_d = 1'b1;
                    end
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_WAIT: begin
                if (cresp_valid) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWN_IBUS) begin
                        idata_ok_d   = 1'b1;
                        iresp_data_d = pick_word(cresp_data, req_q.addr[2]);
                    end else begin
                        ddata_ok_d   = 1'b1;
                        dresp_data_d = cresp_data;
                    end
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                creq_valid_d = 1'b0;
            end
        endcase
    end

    // Arbiter state, latched request and registered master-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= OWN_IBUS;
            owner_q      <= OWN_IBUS;
            req_q        <= CREQ_CLEAR;
            creq_valid_q <= 1'b0;
            iaddr_ok_q   <= 1'b0;
            daddr_ok_q   <= 1'b0;
            idata_ok_q   <= 1'b0;
            ddata_ok_q   <= 1'b0;
            iresp_data_q <= 32'h0000_0000;
            dresp_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            creq_valid_q <= creq_valid_d;
            iaddr_ok_q   <= iaddr_ok_d;
            daddr_ok_q   <= daddr_ok_d;
            idata_ok_q   <= idata_ok_d;
            ddata_ok_q   <= ddata_ok_d;
            iresp_data_q <= iresp_data_d;
            dresp_data_q <= dresp_data_d;
        end
    end

    assign creq_valid    = creq_valid_q;
    assign creq_write    = req_q.write;
    assign creq_addr     = req_q.addr;
    assign creq_size     = req_q.size;
    assign creq_strobe   = req_q.strobe;
    assign creq_data     = req_q.data;
    assign iresp_addr_ok = iaddr_ok_q;
    assign iresp_data_ok = idata_ok_q;
    assign iresp_data    = iresp_data_q;
    assign dresp_addr_ok = daddr_ok_q;
    assign dresp_data_ok = ddata_ok_q;
    assign dresp_data    = dresp_data_q;

`ifdef CORE_BUS_ARB_PERF_EN
    logic [31:0] perf_igrant_q,   perf_igrant_d;
    logic [31:0] perf_dgrant_q,   perf_dgrant_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    // Count grants per master and contended IDLE cycles; counters wrap naturally.
    always_comb begin
        perf_igrant_d   = perf_igrant_q;
        perf_dgrant_d   = perf_dgrant_q;
        perf_conflict_d = perf_conflict_q;
        if (state_q == ARB_IDLE) begin
            if (pick_grant_s && (pick_owner_s == OWN_IBUS)) begin
                perf_igrant_d = perf_igrant_q + 32'd1;
            end else begin
                perf_igrant_d = perf_igrant_q;
            end
            if (pick_grant_s && (pick_owner_s == OWN_DBUS)) begin
                perf_dgrant_d = perf_dgrant_q + 32'd1;
            end else begin
                perf_dgrant_d = perf_dgrant_q;
            end
            if (ireq_valid && dreq_valid) begin
                perf_conflict_d = perf_conflict_q + 32'd1;
            end else begin
                perf_conflict_d = perf_conflict_q;
            end
        end else begin
            perf_conflict_d = perf_conflict_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_igrant_q   <= 32'd0;
            perf_dgrant_q   <= 32'd0;
            perf_conflict_q <= 32'd0;
        end else begin
            perf_igrant_q   <= perf_igrant_d;
            perf_dgrant_q   <= perf_dgrant_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_igrant   = perf_igrant_q;
    assign perf_dgrant   = perf_dgrant_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed testbench for core_bus_arbiter. Inputs change and outputs are sampled
// 1 time unit after each rising edge. Optional counters checked when CORE_BUS_ARB_PERF_EN is set.
module tb_core_bus_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_addr_ok;
    logic              iresp_data_ok;
    logic [31:0]       iresp_data;
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;
    logic              creq_valid;
    logic              creq_ready;
    logic              creq_write;
    logic [ADDR_W-1:0] creq_addr;
    logic [2:0]        creq_size;
    logic [7:0]        creq_strobe;
    logic [DATA_W-1:0] creq_data;
    logic              cresp_valid;
    logic [DATA_W-1:0] cresp_data;
`ifdef CORE_BUS_ARB_PERF_EN
    logic [31:0]       perf_igrant;
    logic [31:0]       perf_dgrant;
    logic [31:0]       perf_conflict;
`endif

    int total = 0;
    int bad   = 0;

    core_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .creq_valid    (creq_valid),
        .creq_ready    (creq_ready),
        .creq_write    (creq_write),
        .creq_addr     (creq_addr),
        .creq_size     (creq_size),
        .creq_strobe   (creq_strobe),
        .creq_data     (creq_data),
        .cresp_valid   (cresp_valid),
        .cresp_data    (cresp_data)
`ifdef CORE_BUS_ARB_PERF_EN
        ,
        .perf_igrant   (perf_igrant),
        .perf_dgrant   (perf_dgrant),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [255:0] all_out;
        rst         = 1'b0;
        cresp_valid = 1'b1;
        cresp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        creq_ready  = 1'b1;
        repeat (3) step();
        all_out = {creq_valid, creq_write, creq_addr, creq_size, creq_strobe, creq_data,
                   iresp_addr_ok, iresp_data_ok, iresp_data,
                   dresp_addr_ok, dresp_data_ok, dresp_data[63:0]};
        total++;
        if (all_out !== 256'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst = 1'b1;
        step();
        step();
        total++;
        if ({creq_valid, iresp_data_ok, dresp_data_ok} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release_idle: creq_valid/idata_ok/ddata_ok=%b want 000",
                     {creq_valid, iresp_data_ok, dresp_data_ok});
        end
        cresp_valid = 1'b0;
        creq_ready  = 1'b0;
        step();
    endtask

    task automatic test_ibus_read();
        // Valid presented in cycle 0; ready/response held high so nothing stalls.
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h0000_0000_8000_0004;
        creq_ready  = 1'b1;
        cresp_valid = 1'b1;
        cresp_data  = 64'h1111_2222_3333_4444;
        step();
        total++;
        if ({creq_valid, creq_write, creq_size, creq_strobe} !== {1'b1, 1'b0, 3'd2, 8'h00}) begin
            bad++;
            $display("FAIL ibus_issue_fields: valid/write/size/strobe=%b/%b/%0d/%h want 1/0/2/00",
                     creq_valid, creq_write, creq_size, creq_strobe);
        end
        total++;
        if (creq_addr !== 64'h0000_0000_8000_0004) begin
            bad++;
            $display("FAIL ibus_issue_addr: got %h want 0000000080000004", creq_addr);
        end
        ireq_valid = 1'b0;
        step();
        total++;
        if ({iresp_addr_ok, iresp_data_ok, dresp_addr_ok} !== 3'b100) begin
            bad++;
            $display("FAIL ibus_addr_ok: iaddr/idata/daddr=%b want 100",
                     {iresp_addr_ok, iresp_data_ok, dresp_addr_ok});
        end
        step();
        // Fourth cycle counting the one where valid was first presented.
        total++;
        if ({iresp_data_ok, dresp_data_ok} !== 2'b10) begin
            bad++;
            $display("FAIL ibus_data_ok_latency: idata/ddata=%b want 10", {iresp_data_ok, dresp_data_ok});
        end
        total++;
        if (iresp_data !== 32'h1111_2222) begin
            bad++;
            $display("FAIL ibus_data_upper: got %h want 11112222", iresp_data);
        end
        creq_ready  = 1'b0;
        cresp_valid = 1'b0;
        step();
        total++;
        if ({iresp_data_ok, creq_valid} !== 2'b00) begin
            bad++;
            $display("FAIL ibus_after_done: idata/creq_valid=%b want 00", {iresp_data_ok, creq_valid});
        end
    endtask

    task automatic test_dbus_write();
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h0000_0000_0000_0100;
        dreq_size   = 3'd2;
        dreq_strobe = 8'h0F;
        dreq_data   = 64'h0000_0000_DEAD_BEEF;
        step();
        dreq_valid  = 1'b0;
        dreq_addr   = 64'h0;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({creq_valid, creq_write, creq_addr, creq_size, creq_strobe, creq_data, dresp_addr_ok} !==
                {1'b1, 1'b1, 64'h100, 3'd2, 8'h0F, 64'hDEAD_BEEF, 1'b0}) begin
                bad++;
                $display("FAIL dbus_stall_%0d: v/w/a/sz/st/d/aok=%b/%b/%h/%0d/%h/%h/%b want 1/1/100/2/0f/deadbeef/0",
                         i, creq_valid, creq_write, creq_addr, creq_size, creq_strobe, creq_data, dresp_addr_ok);
            end
            if (i == 2) begin
                creq_ready = 1'b1;
            end else begin
                creq_ready = 1'b0;
            end
            step();
        end
        total++;
        if ({dresp_addr_ok, iresp_addr_ok, creq_valid} !== 3'b100) begin
            bad++;
            $display("FAIL dbus_addr_ok: daddr/iaddr/creq_valid=%b want 100",
                     {dresp_addr_ok, iresp_addr_ok, creq_valid});
        end
        creq_ready  = 1'b0;
        cresp_valid = 1'b1;
        cresp_data  = 64'h0123_4567_89AB_CDEF;
        step();
        cresp_valid = 1'b0;
        total++;
        if ({dresp_data_ok, iresp_data_ok} !== 2'b10 || dresp_data !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL dbus_write_done: ddata/idata=%b data=%h want 10 0123456789abcdef",
                     {dresp_data_ok, iresp_data_ok}, dresp_data);
        end
        step();
    endtask

    task automatic test_round_robin();
        int  n_addr;
        int  n_data;
        logic exp_d;
        n_addr = 0;
        n_data = 0;
        exp_d  = 1'b1;
        rst = 1'b0;
        step();
        rst         = 1'b1;
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h0000_0000_0000_2000;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h0000_0000_0000_3000;
        dreq_size   = 3'd3;
        dreq_strobe = 8'h00;
        creq_ready  = 1'b1;
        cresp_valid = 1'b1;
        cresp_data  = 64'h5A5A_5A5A_A5A5_A5A5;
        for (int c = 1; c <= 18; c++) begin
            step();
            total++;
            if (((iresp_addr_ok | iresp_data_ok) & (dresp_addr_ok | dresp_data_ok)) !== 1'b0) begin
                bad++;
                $display("FAIL rr_concurrent_c%0d: i=%b%b d=%b%b", c,
                         iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok);
            end
            if (iresp_addr_ok === 1'b1 || dresp_addr_ok === 1'b1) begin
                total++;
                if (dresp_addr_ok !== exp_d) begin
                    bad++;
                    $display("FAIL rr_order_grant%0d: dbus=%b want %b", n_addr, dresp_addr_ok, exp_d);
                end
                exp_d = ~exp_d;
                n_addr++;
            end
            if (iresp_data_ok === 1'b1 || dresp_data_ok === 1'b1) begin
                n_data++;
            end
        end
        total++;
        if (n_addr !== 6 || n_data !== 6) begin
            bad++;
            $display("FAIL rr_counts: addr_ok=%0d data_ok=%0d want 6 6", n_addr, n_data);
        end
`ifdef CORE_BUS_ARB_PERF_EN
        total++;
        if ({perf_igrant, perf_dgrant, perf_conflict} !== {32'd3, 32'd3, 32'd6}) begin
            bad++;
            $display("FAIL rr_perf: igrant=%0d dgrant=%0d conflict=%0d want 3 3 6",
                     perf_igrant, perf_dgrant, perf_conflict);
        end
`endif
        ireq_valid  = 1'b0;
        dreq_valid  = 1'b0;
        creq_ready  = 1'b0;
        cresp_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_in_wait();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h0000_0000_0000_1000;
        creq_ready = 1'b1;
        step();
        ireq_valid = 1'b0;
        step();
        total++;
        if (iresp_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL rstwait_reach_wait: iaddr_ok=%b want 1", iresp_addr_ok);
        end
        creq_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if ({iresp_addr_ok, creq_valid} !== 2'b00) begin
            bad++;
            $display("FAIL rstwait_async_clear: iaddr/creq_valid=%b want 00", {iresp_addr_ok, creq_valid});
        end
        step();
        rst         = 1'b1;
        cresp_valid = 1'b1;
        cresp_data  = 64'h7777_8888_9999_AAAA;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({iresp_data_ok, dresp_data_ok, creq_valid} !== 3'b000) begin
                bad++;
                $display("FAIL rstwait_stale_c%0d: idata/ddata/creq_valid=%b want 000",
                         c, {iresp_data_ok, dresp_data_ok, creq_valid});
            end
        end
        cresp_valid = 1'b0;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h0000_0000_0000_0200;
        dreq_size   = 3'd3;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0;
        step();
        total++;
        if ({creq_valid, creq_write, creq_size} !== {1'b1, 1'b0, 3'd3} || creq_addr !== 64'h200) begin
            bad++;
            $display("FAIL rstwait_next_issue: v/w/sz/a=%b/%b/%0d/%h want 1/0/3/200",
                     creq_valid, creq_write, creq_size, creq_addr);
        end
        dreq_valid  = 1'b0;
        creq_ready  = 1'b1;
        cresp_valid = 1'b1;
        cresp_data  = 64'hCAFE_F00D_1234_5678;
        step();
        step();
        total++;
        if (dresp_data_ok !== 1'b1 || dresp_data !== 64'hCAFE_F00D_1234_5678) begin
            bad++;
            $display("FAIL rstwait_next_read: ddata_ok=%b data=%h want 1 cafef00d12345678",
                     dresp_data_ok, dresp_data);
        end
        creq_ready  = 1'b0;
        cresp_valid = 1'b0;
        step();
    endtask

    task automatic test_drop_in_issue();
        int n_ok;
        n_ok = 0;
        ireq_valid = 1'b1;
        ireq_addr  = 64'h0000_0000_8000_0010;
        step();
        ireq_valid = 1'b0;
        step();
        total++;
        if (creq_valid !== 1'b1 || creq_addr !== 64'h8000_0010) begin
            bad++;
            $display("FAIL drop_still_issuing: creq_valid=%b addr=%h want 1 80000010", creq_valid, creq_addr);
        end
        creq_ready = 1'b1;
        step();
        creq_ready  = 1'b0;
        cresp_valid = 1'b1;
        cresp_data  = 64'hAAAA_5555_0102_0304;
        step();
        cresp_valid = 1'b0;
        total++;
        if (iresp_data_ok !== 1'b1 || iresp_data !== 32'h0102_0304) begin
            bad++;
            $display("FAIL drop_data_lower: idata_ok=%b data=%h want 1 01020304", iresp_data_ok, iresp_data);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (iresp_data_ok === 1'b1 || creq_valid === 1'b1) begin
                n_ok++;
            end
        end
        total++;
        if (n_ok !== 0) begin
            bad++;
            $display("FAIL drop_returns_idle: extra activity cycles=%0d want 0", n_ok);
        end
    endtask

    initial begin
        rst         = 1'b0;
        ireq_valid  = 1'b0;
        ireq_addr   = 64'h0;
        dreq_valid  = 1'b0;
        dreq_addr   = 64'h0;
        dreq_size   = 3'd0;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0;
        creq_ready  = 1'b0;
        cresp_valid = 1'b0;
        cresp_data  = 64'h0;
        test_reset();
        test_ibus_read();
        test_dbus_write();
        test_round_robin();
        test_reset_in_wait();
        test_drop_in_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
